// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: datapath sizes, register write-back commands and
// the opcodes decoded by the CPU control FSM.
package mcpu_pkg;

  localparam int unsigned WORD_SIZE    = 16;
  localparam int unsigned OPERAND_SIZE = 4;

  typedef enum logic [1:0] {
    NORMAL_EX      = 2'd0,
    LOAD_FROM_DATA = 2'd1,
    MOV_INTERNAL   = 2'd2,
    DO_NOTHING     = 2'd3
  } regsetcmd_e;

  typedef enum logic [3:0] {
    OpAnd  = 4'd0,
    OpOr   = 4'd1,
    OpXor  = 4'd2,
    OpNot  = 4'd3,
    OpAdd  = 4'd4,
    OpSub  = 4'd5,
    OpLoad = 4'd8,
    OpStor = 4'd9,
    OpMov  = 4'd10,
    OpLdc  = 4'd11,
    OpBnz  = 4'd12,
    OpNop  = 4'd15
  } opcode_e;

endpackage

// File: rtl/mcpu_regfile_wbmux.sv
// Register-file write-back select: picks the write data and write enable
// from the write-back command.
module mcpu_regfile_wbmux
  import mcpu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = mcpu_pkg::WORD_SIZE
) (
  input  logic [1:0]           regsetcmd,
  input  logic                 regsetwb,
  input  logic [WORD_SIZE-1:0] datatoload,
  input  logic [WORD_SIZE-1:0] mov_data,
  output logic                 wr_en,
  output logic [WORD_SIZE-1:0] wr_data
);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = datatoload;
    unique case (regsetcmd_e'(regsetcmd))
      NORMAL_EX, LOAD_FROM_DATA: begin
        wr_en   = regsetwb;
        wr_data = datatoload;
      end
      MOV_INTERNAL: begin
        wr_en   = regsetwb;
        wr_data = mov_data;
      end
      DO_NOTHING: begin
        wr_en   = 1'b0;
        wr_data = datatoload;
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = datatoload;
      end
    endcase
  end

endmodule

// File: rtl/mcpu_registerfile.sv
// MCPU register file: flat array with three combinational read ports and a
// single synchronous write port; synchronous active-high reset clears it.
module mcpu_registerfile
  import mcpu_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = mcpu_pkg::WORD_SIZE,
  parameter int unsigned OPERAND_SIZE = mcpu_pkg::OPERAND_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPERAND_SIZE-1:0] op1,
  input  logic [OPERAND_SIZE-1:0] op2,
  input  logic [OPERAND_SIZE-1:0] op3,
  input  logic [1:0]              regsetcmd,
  input  logic                    regsetwb,
  input  logic [WORD_SIZE-1:0]    datatoload,
  output logic [WORD_SIZE-1:0]    alu1,
  output logic [WORD_SIZE-1:0]    alu2,
  output logic [WORD_SIZE-1:0]    RegOp1
);

  localparam int unsigned NumRegs = 2 ** OPERAND_SIZE;

  logic [WORD_SIZE-1:0] regs_q [NumRegs];
  logic                 wr_en;
  logic [WORD_SIZE-1:0] wr_data;

  // No write-through: reads see the array only, so new data appears after the edge.
  assign alu1   = regs_q[op2];
  assign alu2   = regs_q[op3];
  assign RegOp1 = regs_q[op1];

  mcpu_regfile_wbmux #(
    .WORD_SIZE (WORD_SIZE)
  ) u_wbmux (
    .regsetcmd  (regsetcmd),
    .regsetwb   (regsetwb),
    .datatoload (datatoload),
    .mov_data   (alu1),
    .wr_en      (wr_en),
    .wr_data    (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[op1] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mcpu_registerfile.sv
// Directed, table-driven bench for the MCPU register file.
module tb_mcpu_registerfile;
  import mcpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op1, op2, op3;
  logic [1:0]  regsetcmd;
  logic        regsetwb;
  logic [15:0] datatoload;
  logic [15:0] alu1, alu2, RegOp1;

  int tests  = 0;
  int failed = 0;

  mcpu_registerfile dut (
    .clk        (clk),
    .reset      (reset),
    .op1        (op1),
    .op2        (op2),
    .op3        (op3),
    .regsetcmd  (regsetcmd),
    .regsetwb   (regsetwb),
    .datatoload (datatoload),
    .alu1       (alu1),
    .alu2       (alu2),
    .RegOp1     (RegOp1)
  );

  always #5 clk = ~clk;

  // One write-phase edge, then read indices and expected outputs.
  typedef struct {
    string       name;
    logic        rst;
    logic        wb;
    logic [1:0]  cmd;
    logic [3:0]  wop1;
    logic [3:0]  wop2;
    logic [15:0] data;
    logic [3:0]  rop1;
    logic [3:0]  rop2;
    logic [3:0]  rop3;
    logic [15:0] e_regop1;
    logic [15:0] e_alu1;
    logic [15:0] e_alu2;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      op1 = 4'(i); op2 = 4'(i); op3 = 4'(i);
      #1;
      check($sformatf("%s RegOp1[%0d]", name, i), RegOp1, 16'h0000);
      check($sformatf("%s alu1[%0d]", name, i), alu1, 16'h0000);
      check($sformatf("%s alu2[%0d]", name, i), alu2, 16'h0000);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst, input logic wb,
                              input logic [1:0] cmd, input logic [3:0] wop1,
                              input logic [3:0] wop2, input logic [15:0] data,
                              input logic [3:0] rop1, input logic [3:0] rop2,
                              input logic [3:0] rop3, input logic [15:0] e_regop1,
                              input logic [15:0] e_alu1, input logic [15:0] e_alu2);
    vec_t v;
    v.name = name; v.rst = rst; v.wb = wb; v.cmd = cmd; v.wop1 = wop1; v.wop2 = wop2;
    v.data = data; v.rop1 = rop1; v.rop2 = rop2; v.rop3 = rop3;
    v.e_regop1 = e_regop1; v.e_alu1 = e_alu1; v.e_alu2 = e_alu2;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk("load_r3",     0, 1, LOAD_FROM_DATA, 3, 0, 16'h00A5, 3, 3, 0,
                  16'h00A5, 16'h00A5, 16'h0000);
    vecs[1]  = mk("mov_r7_r3",   0, 1, MOV_INTERNAL,   7, 3, 16'hFFFF, 7, 7, 3,
                  16'h00A5, 16'h00A5, 16'h00A5);
    vecs[2]  = mk("do_nothing",  0, 1, DO_NOTHING,     5, 0, 16'hBEEF, 5, 5, 5,
                  16'h0000, 16'h0000, 16'h0000);
    vecs[3]  = mk("wb_low",      0, 0, NORMAL_EX,      5, 0, 16'hBEEF, 5, 5, 5,
                  16'h0000, 16'h0000, 16'h0000);
    vecs[4]  = mk("write_r0",    0, 1, NORMAL_EX,      0, 0, 16'h1111, 0, 0, 3,
                  16'h1111, 16'h1111, 16'h00A5);
    vecs[5]  = mk("mov_self",    0, 1, MOV_INTERNAL,   3, 3, 16'hDEAD, 3, 3, 7,
                  16'h00A5, 16'h00A5, 16'h00A5);
    vecs[6]  = mk("reset_prio",  1, 1, NORMAL_EX,      2, 0, 16'h1234, 2, 3, 7,
                  16'h0000, 16'h0000, 16'h0000);
    vecs[7]  = mk("after_reset", 0, 1, NORMAL_EX,      2, 0, 16'h1234, 2, 3, 0,
                  16'h1234, 16'h0000, 16'h0000);
    vecs[8]  = mk("write_r1",    0, 1, NORMAL_EX,      1, 0, 16'h0003, 1, 2, 0,
                  16'h0003, 16'h1234, 16'h0000);
    vecs[9]  = mk("write_r2",    0, 1, LOAD_FROM_DATA, 2, 0, 16'h0004, 1, 1, 2,
                  16'h0003, 16'h0003, 16'h0004);
    vecs[10] = mk("write_r15",   0, 1, NORMAL_EX,     15, 0, 16'h8001, 15, 14, 0,
                  16'h8001, 16'h0000, 16'h0000);

    reset = 1'b1; regsetwb = 1'b0; regsetcmd = NORMAL_EX;
    op1 = '0; op2 = '0; op3 = '0; datatoload = '0;
    tick();
    reset = 1'b0;
    sweep_zero("reset");

    for (int i = 0; i < 11; i++) begin
      reset = vecs[i].rst; regsetwb = vecs[i].wb; regsetcmd = vecs[i].cmd;
      op1 = vecs[i].wop1; op2 = vecs[i].wop2; op3 = 4'd0; datatoload = vecs[i].data;
      tick();
      reset = 1'b0; regsetwb = 1'b0; regsetcmd = DO_NOTHING;
      op1 = vecs[i].rop1; op2 = vecs[i].rop2; op3 = vecs[i].rop3;
      #1;
      check({vecs[i].name, " RegOp1"}, RegOp1, vecs[i].e_regop1);
      check({vecs[i].name, " alu1"}, alu1, vecs[i].e_alu1);
      check({vecs[i].name, " alu2"}, alu2, vecs[i].e_alu2);
      if (i == 0) begin
        for (int r = 0; r < 16; r++) begin
          op1 = 4'(r);
          #1;
          check($sformatf("load_r3 only R%0d", r), RegOp1, (r == 3) ? 16'h00A5 : 16'h0000);
        end
      end
    end

    // Combinational reads before the edge, new value only after it.
    op1 = 4'd1; op2 = 4'd1; op3 = 4'd2;
    regsetcmd = NORMAL_EX; datatoload = 16'h0007; regsetwb = 1'b1;
    #1;
    check("raw pre alu1", alu1, 16'h0003);
    check("raw pre alu2", alu2, 16'h0004);
    check("raw pre RegOp1", RegOp1, 16'h0003);
    @(posedge clk);
    #1;
    regsetwb = 1'b0;
    check("raw post alu1", alu1, 16'h0007);
    check("raw post alu2", alu2, 16'h0004);
    check("raw post RegOp1", RegOp1, 16'h0007);

    // Held write-back repeats idempotently and touches only the target.
    op1 = 4'd4; op2 = 4'd1; op3 = 4'd2;
    regsetcmd = NORMAL_EX; datatoload = 16'h5A5A; regsetwb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("held wb R4 c%0d", c), RegOp1, 16'h5A5A);
      check($sformatf("held wb R1 c%0d", c), alu1, 16'h0007);
    end
    regsetwb = 1'b0;

    // Reset between write-backs discards everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep_zero("rereset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mcpu_registerfile.md
MCPU_REGISTERFILE -- requirements
Module: mcpu_registerfile

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: register and data width in bits.
REQ-002 SHALL have parameter OPERAND_SIZE, default 4: register-index width; register count is 2**OPERAND_SIZE, 16 by default.
REQ-003 Port clk, input, 1: clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset, sampled on clk.
REQ-005 Port op1, input, OPERAND_SIZE: destination index, also the RegOp1 read index.
REQ-006 Port op2, input, OPERAND_SIZE: first source index, drives alu1 and is the MOV source.
REQ-007 Port op3, input, OPERAND_SIZE: second source index, drives alu2.
REQ-008 Port regsetcmd, input, 2: write-back command (see REQ-013).
REQ-009 Port regsetwb, input, 1: write-back enable, sampled on clk.
REQ-010 Port datatoload, input, WORD_SIZE: write data (ALU result, RAM read data, or short constant), selected outside the block.
REQ-011 Ports alu1 and alu2, output, WORD_SIZE each: contents of R[op2] and R[op3].
REQ-012 Port RegOp1, output, WORD_SIZE: contents of R[op1], used as store data and BNZ test value.

Function
REQ-013 Command encoding: NORMAL_EX=2'd0, LOAD_FROM_DATA=2'd1, MOV_INTERNAL=2'd2, DO_NOTHING=2'd3.
REQ-014 Reads: alu1, alu2 and RegOp1 SHALL be combinational from the register array and index inputs, with zero-cycle latency.
REQ-015 Read-after-write: reads SHALL show the old value until the write edge and the new value immediately after it; there is no write-through bypass.
REQ-016 On a rising clk with reset=0, regsetwb=1 and regsetcmd=NORMAL_EX: R[op1] <= datatoload.
REQ-017 On a rising clk with reset=0, regsetwb=1 and regsetcmd=LOAD_FROM_DATA: R[op1] <= datatoload.
REQ-018 On a rising clk with reset=0, regsetwb=1 and regsetcmd=MOV_INTERNAL: R[op1] <= R[op2], using the pre-edge value; datatoload is ignored.
REQ-019 With regsetcmd=DO_NOTHING, or regsetwb=0, no register SHALL change.
REQ-020 At most one register SHALL be written per cycle; all other registers hold their values.
REQ-021 With op1==op2 under MOV_INTERNAL, the register SHALL keep its value.
REQ-022 No register is hardwired; R0 is writable like any other register.
REQ-023 regsetwb held high for several cycles SHALL repeat the write on every edge; the result is idempotent for stable inputs.
REQ-024 The block SHALL contain no other state: no flags and no pipeline registers.

Reset
REQ-025 On a rising clk with reset=1, all registers SHALL be cleared to 0, so all outputs read 0.
REQ-026 Reset SHALL take priority over a simultaneous regsetwb=1, which performs no write.
REQ-027 Reset asserted between two write-backs SHALL discard all earlier contents, with no partial retention.

Structure
REQ-028 A shared package mcpu_pkg SHALL hold WORD_SIZE, OPERAND_SIZE and the regsetcmd encodings, which mcpu_registerfile and the CPU control FSM both use.
REQ-029 The package SHALL also hold the opcode constants used by that FSM, e.g. for the ALU, RAM and BNZ operations.
REQ-030 The register array SHALL be a single flat array of 2**OPERAND_SIZE words; three independent combinational read ports are required.
REQ-031 A sub-module mcpu_regfile_wbmux SHALL select the write data (datatoload or R[op2]) and the write enable from regsetcmd and regsetwb.

Verification
REQ-032 Reset, then sweep op1, op2 and op3 over 0..15 -> RegOp1, alu1 and alu2 read 16'h0000 for every index.
REQ-033 regsetcmd=LOAD_FROM_DATA, op1=3, datatoload=16'h00A5, regsetwb pulsed one cycle -> RegOp1(op1=3)=16'h00A5, and all other registers stay 0.
REQ-034 R3=16'h00A5 preloaded, then regsetcmd=MOV_INTERNAL, op1=7, op2=3, datatoload=16'hFFFF, regsetwb pulsed -> R7=16'h00A5, datatoload ignored.
REQ-035 NORMAL_EX, op1=2, datatoload=16'h1234, regsetwb=1 on the same edge as reset=1 -> R2=0; the following edge with reset=0 -> R2=16'h1234.
REQ-036 DO_NOTHING with regsetwb=1, op1=5, datatoload=16'hBEEF -> R5 unchanged. Also: regsetwb=0 with NORMAL_EX -> no register changes.
REQ-037 R1=16'h0003 and R2=16'h0004, op1=1, op2=1, op3=2 -> alu1=16'h0003, alu2=16'h0004 and RegOp1=16'h0003 combinationally. Then NORMAL_EX writeback of datatoload=16'h0007 to op1=1 -> alu1=16'h0007 only after the edge.
